// File: rtl/lifegame_gen_ctrl_if.sv
// ============================================================================
// Module   : lifegame_gen_ctrl_if
// Purpose  : Bundles the raster timing, seed-RAM, engine handshake and status
//            signals of the life-game generation scheduler.
//            Optional LIFEGAME_SINGLE_STEP_EN adds the step input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface lifegame_gen_ctrl_if #(
    parameter int CELLS_W = 64,
    parameter int CELLS_H = 48
);
    localparam int ADDR_W = $clog2(CELLS_W * CELLS_H);

    logic [9:0]        h_count;
    logic [9:0]        v_count;
    logic              run;
    logic              reseed;
    logic              lfsr_bit;
    logic              eng_done;
`ifdef LIFEGAME_SINGLE_STEP_EN
    logic              step;
`endif
    logic              eng_start;
    logic              eng_abort;
    logic              seed_we;
    logic [ADDR_W-1:0] seed_addr;
    logic              seed_wdata;
    logic              disp_bank;
    logic              wr_bank;
    logic [15:0]       gen_count;
    logic              overrun;
    logic              busy;

    modport master (
        input  h_count, v_count, run, reseed, lfsr_bit, eng_done,
`ifdef LIFEGAME_SINGLE_STEP_EN
        input  step,
`endif
        output eng_start, eng_abort, seed_we, seed_addr, seed_wdata,
        output disp_bank, wr_bank, gen_count, overrun, busy
    );

    modport slave (
        output h_count, v_count, run, reseed, lfsr_bit, eng_done,
`ifdef LIFEGAME_SINGLE_STEP_EN
        output step,
`endif
        input  eng_start, eng_abort, seed_we, seed_addr, seed_wdata,
        input  disp_bank, wr_bank, gen_count, overrun, busy
    );
endinterface

`default_nettype wire

// File: rtl/lifegame_gen_ctrl.sv
// ============================================================================
// Module   : lifegame_gen_ctrl
// Purpose  : Seeds the double-buffered cell RAM from the LFSR, launches one
//            generation every GEN_DIV frames and swaps banks in vblank.
//            Optional LIFEGAME_SINGLE_STEP_EN enables single-step requests.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lifegame_gen_ctrl #(
    parameter int CELLS_W  = 64,
    parameter int CELLS_H  = 48,
    parameter int GEN_DIV  = 4,
    parameter int V_ACTIVE = 480
) (
    input  wire logic               clk,
    input  wire logic               rst,
    lifegame_gen_ctrl_if.master     bus
);
    localparam int                N_CELLS    = CELLS_W * CELLS_H;
    localparam int                ADDR_W     = $clog2(N_CELLS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_CELLS - 1);
    localparam logic [7:0]        LAST_FRAME = 8'(GEN_DIV - 1);
    localparam logic [9:0]        VB_LINE    = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2,
        ST_SWAP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] seed_addr_q, seed_addr_d;
    logic              seed_we_q, seed_we_d;
    logic              eng_start_q, eng_start_d;
    logic              eng_abort_q, eng_abort_d;
    logic              disp_bank_q, disp_bank_d;
    logic [15:0]       gen_count_q, gen_count_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        frame_q, frame_d;
    logic              reseed_q, reseed_d;
    logic              vb_start, vb_end, gen_due;

    assign vb_start = (bus.v_count == VB_LINE) && (bus.h_count == 10'd0);
    assign vb_end   = (bus.v_count == 10'd0)   && (bus.h_count == 10'd0);

`ifdef LIFEGAME_SINGLE_STEP_EN
    logic step_q, step_d;
    assign gen_due = (bus.run && (frame_q == LAST_FRAME)) || step_q;
`else
    assign gen_due = bus.run && (frame_q == LAST_FRAME);
`endif

    always_comb begin
        state_d     = state_q;
        seed_addr_d = seed_addr_q;
        seed_we_d   = seed_we_q;
        eng_start_d = 1'b0;
        eng_abort_d = 1'b0;
        disp_bank_d = disp_bank_q;
        gen_count_d = gen_count_q;
        overrun_d   = overrun_q;
        frame_d     = frame_q;
        reseed_d    = reseed_q | bus.reseed;
`ifdef LIFEGAME_SINGLE_STEP_EN
        step_d      = step_q | (bus.step & ~bus.run);
`endif
        case (state_q)
            ST_SEED: begin
                // The write enable is armed one cycle after reset, then one cell per cycle.
                if (!seed_we_q) begin
                    seed_we_d = 1'b1;
                end else if (seed_addr_q == LAST_ADDR) begin
                    seed_we_d   = 1'b0;
                    seed_addr_d = '0;
                    frame_d     = 8'd0;
                    state_d     = ST_WAIT;
                end else begin
                    seed_addr_d = seed_addr_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (vb_start) begin
                    if (reseed_q) begin
                        reseed_d    = bus.reseed;
                        seed_we_d   = 1'b1;
                        seed_addr_d = '0;
                        state_d     = ST_SEED;
                    end else if (gen_due) begin
                        frame_d     = 8'd0;
                        eng_start_d = 1'b1;
                        state_d     = ST_STEP;
`ifdef LIFEGAME_SINGLE_STEP_EN
                        step_d      = bus.step & ~bus.run;
`endif
                    end else if (bus.run) begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            ST_STEP: begin
                if (bus.eng_done) begin
                    state_d = ST_SWAP;
                end else if (vb_end) begin
                    eng_abort_d = 1'b1;
                    overrun_d   = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_SWAP: begin
                disp_bank_d = ~disp_bank_q;
                gen_count_d = gen_count_q + 16'd1;
                state_d     = ST_WAIT;
            end
            default: state_d = ST_SEED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEED;
            seed_addr_q <= '0;
            seed_we_q   <= 1'b0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
            disp_bank_q <= 1'b0;
            gen_count_q <= 16'd0;
            overrun_q   <= 1'b0;
            frame_q     <= 8'd0;
            reseed_q    <= 1'b0;
`ifdef LIFEGAME_SINGLE_STEP_EN
            step_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            seed_addr_q <= seed_addr_d;
            seed_we_q   <= seed_we_d;
            eng_start_q <= eng_start_d;
            eng_abort_q <= eng_abort_d;
            disp_bank_q <= disp_bank_d;
            gen_count_q <= gen_count_d;
            overrun_q   <= overrun_d;
            frame_q     <= frame_d;
            reseed_q    <= reseed_d;
`ifdef LIFEGAME_SINGLE_STEP_EN
            step_q      <= step_d;
`endif
        end
    end

    assign bus.eng_start  = eng_start_q;
    assign bus.eng_abort  = eng_abort_q;
    assign bus.seed_we    = seed_we_q;
    assign bus.seed_addr  = seed_addr_q;
    assign bus.seed_wdata = bus.lfsr_bit;
    assign bus.disp_bank  = disp_bank_q;
    assign bus.wr_bank    = ~disp_bank_q;
    assign bus.gen_count  = gen_count_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q == ST_SEED) || (state_q == ST_STEP);

endmodule

`default_nettype wire

// File: tb/tb_lifegame_gen_ctrl.sv
// ============================================================================
// Module   : tb_lifegame_gen_ctrl
// Purpose  : Directed self-checking bench for lifegame_gen_ctrl (4x2 grid,
//            GEN_DIV = 2). Optional LIFEGAME_SINGLE_STEP_EN steps are covered.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lifegame_gen_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lifegame_gen_ctrl_if #(.CELLS_W(4), .CELLS_H(2)) bus ();

    lifegame_gen_ctrl #(
        .CELLS_W (4),
        .CELLS_H (2),
        .GEN_DIV (2),
        .V_ACTIVE(480)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vbs();
        bus.v_count = 10'd480; bus.h_count = 10'd0;
        tick();
        bus.v_count = 10'd100; bus.h_count = 10'd5;
    endtask

    task automatic vbe();
        bus.v_count = 10'd0; bus.h_count = 10'd0;
        tick();
        bus.v_count = 10'd100; bus.h_count = 10'd5;
    endtask

    task automatic done_pulse();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
    endtask

    task automatic pulse_reseed();
        bus.reseed = 1'b1;
        tick();
        bus.reseed = 1'b0;
    endtask

    task automatic seed_run(input string tag, input logic bank);
        for (int i = 0; i < 8; i++) begin
            bus.lfsr_bit = i[0];
            #1;
            check({tag, "_we"}, 32'(bus.seed_we), 32'd1);
            check({tag, "_addr"}, 32'(bus.seed_addr), 32'(i));
            check({tag, "_wdata"}, 32'(bus.seed_wdata), 32'(i[0]));
            check({tag, "_bank"}, 32'(bus.disp_bank), 32'(bank));
            tick();
        end
        check({tag, "_we_end"}, 32'(bus.seed_we), 32'd0);
        check({tag, "_addr_end"}, 32'(bus.seed_addr), 32'd0);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.h_count  = 10'd5;
        bus.v_count  = 10'd100;
        bus.run      = 1'b0;
        bus.reseed   = 1'b0;
        bus.lfsr_bit = 1'b0;
        bus.eng_done = 1'b0;
`ifdef LIFEGAME_SINGLE_STEP_EN
        bus.step     = 1'b0;
`endif
        tick(); tick();
        check("rst_we", 32'(bus.seed_we), 32'd0);
        check("rst_addr", 32'(bus.seed_addr), 32'd0);
        check("rst_start", 32'(bus.eng_start), 32'd0);
        check("rst_disp", 32'(bus.disp_bank), 32'd0);
        check("rst_wr", 32'(bus.wr_bank), 32'd1);
        check("rst_gen", 32'(bus.gen_count), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);

        rst = 1'b0;
        tick();
        seed_run("seed0", 1'b0);

        // Generation 1: start on every second vb_start
        bus.run = 1'b1;
        vbs();
        check("g1_nostart", 32'(bus.eng_start), 32'd0);
        vbe();
        vbs();
        check("g1_start", 32'(bus.eng_start), 32'd1);
        check("g1_busy", 32'(bus.busy), 32'd1);
        tick();
        check("g1_start_pulse", 32'(bus.eng_start), 32'd0);
        repeat (98) tick();
        done_pulse();
        check("g1_swap_busy", 32'(bus.busy), 32'd0);
        check("g1_swap_disp", 32'(bus.disp_bank), 32'd0);
        tick();
        check("g1_disp", 32'(bus.disp_bank), 32'd1);
        check("g1_wr", 32'(bus.wr_bank), 32'd0);
        check("g1_gen", 32'(bus.gen_count), 32'd1);
        done_pulse();
        tick();
        check("stray_done_gen", 32'(bus.gen_count), 32'd1);

        // Generation 2
        vbs(); vbs();
        check("g2_start", 32'(bus.eng_start), 32'd1);
        repeat (98) tick();
        done_pulse();
        tick();
        check("g2_disp", 32'(bus.disp_bank), 32'd0);
        check("g2_gen", 32'(bus.gen_count), 32'd2);

        // Overrun: engine never finishes
        vbs(); vbs();
        check("ab_start", 32'(bus.eng_start), 32'd1);
        tick();
        vbe();
        check("ab_abort", 32'(bus.eng_abort), 32'd1);
        check("ab_ovr", 32'(bus.overrun), 32'd1);
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_disp", 32'(bus.disp_bank), 32'd0);
        check("ab_gen", 32'(bus.gen_count), 32'd2);
        tick();
        check("ab_abort_pulse", 32'(bus.eng_abort), 32'd0);
        done_pulse();
        tick();
        check("ab_late_done", 32'(bus.gen_count), 32'd2);

        // done and vb_end together: done wins
        vbs(); vbs();
        tick();
        bus.eng_done = 1'b1; bus.v_count = 10'd0; bus.h_count = 10'd0;
        tick();
        bus.eng_done = 1'b0; bus.v_count = 10'd100; bus.h_count = 10'd5;
        check("tie_abort", 32'(bus.eng_abort), 32'd0);
        tick();
        check("tie_gen", 32'(bus.gen_count), 32'd3);
        check("tie_disp", 32'(bus.disp_bank), 32'd1);
        check("tie_ovr_sticky", 32'(bus.overrun), 32'd1);

        // Reseed during STEP, serviced at the next WAIT vb_start
        vbs(); vbs();
        tick();
        pulse_reseed();
        done_pulse();
        tick();
        check("rs_gen", 32'(bus.gen_count), 32'd4);
        vbs();
        check("rs_nostart", 32'(bus.eng_start), 32'd0);
        check("rs_busy", 32'(bus.busy), 32'd1);
        seed_run("seed1", 1'b0);

        // Reseed in the frame a generation is due; pulses collapse
        vbs();
        check("rs2_nostart_a", 32'(bus.eng_start), 32'd0);
        pulse_reseed();
        pulse_reseed();
        vbs();
        check("rs2_nostart_b", 32'(bus.eng_start), 32'd0);
        seed_run("seed2", 1'b0);
        vbs();
        check("rs2_frame_clr", 32'(bus.eng_start), 32'd0);
        vbs();
        check("rs2_resume", 32'(bus.eng_start), 32'd1);
        done_pulse();
        tick();
        check("rs2_gen", 32'(bus.gen_count), 32'd5);

        // Reset in the middle of seeding
        pulse_reseed();
        vbs();
        repeat (5) tick();
        check("mr_addr5", 32'(bus.seed_addr), 32'd5);
        rst = 1'b1;
        tick();
        check("mr_we", 32'(bus.seed_we), 32'd0);
        check("mr_addr", 32'(bus.seed_addr), 32'd0);
        check("mr_disp", 32'(bus.disp_bank), 32'd0);
        check("mr_gen", 32'(bus.gen_count), 32'd0);
        check("mr_ovr", 32'(bus.overrun), 32'd0);
        check("mr_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        bus.run = 1'b0;
        tick();
        seed_run("seed3", 1'b0);

`ifdef LIFEGAME_SINGLE_STEP_EN
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        vbs();
        check("ss_start", 32'(bus.eng_start), 32'd1);
        tick();
        done_pulse();
        tick();
        check("ss_gen", 32'(bus.gen_count), 32'd1);
        for (int k = 0; k < 3; k++) begin
            vbs();
            check("ss_nostart", 32'(bus.eng_start), 32'd0);
        end
`else
        vbs(); vbs(); vbs();
        check("norun_nostart", 32'(bus.eng_start), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
